matrix_scan_ctrl: RTL and testbench
===================================

Name: matrix_scan_ctrl

Overview:
Scan controller for the 5-column x 7-row LED dot-matrix display.
- Steps the 3-bit column select driving the column decoder (sel 0..4) at a fixed slot rate.
- Drives the active-low row lines with the stored pattern for the selected column, with a blanking gap before each column to suppress ghosting.
- Holds a double-buffered frame image; new images are loaded by a strobe and swapped in only at frame boundaries.

Parameters:
CLK_DIV, 50000, clock cycles per column slot (must be > BLANK_CYCLES + 1)
BLANK_CYCLES, 4, cycles at the start of each slot with rows forced off
NUM_COLS, 5, columns scanned per frame (col_sel range 0..NUM_COLS-1, max 8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan running; 0 = display idle/blank
load  in  1  one-cycle strobe: capture load_data into the shadow buffer
load_data  in  35  frame image; bits [7c+6:7c] = rows 6..0 of column c, 1 = LED on
load_ack  out  1  one-cycle pulse, the cycle after load is accepted
col_sel  out  3  column index to the column decoder
row_n  out  7  row drive, active low (1 = off)
blank  out  1  1 while rows are forced off
frame_done  out  1  one-cycle pulse at the end of the last column's slot
pending  out  1  shadow buffer holds an image not yet displayed

Behaviour:
- Reset (async): state=IDLE, col_sel=0, row_n=7'h7F, blank=1, load_ack=0, frame_done=0, pending=0, both buffers=0, slot counter=0.
- States:
  - IDLE: blank=1, row_n=7'h7F, col_sel=0, counter=0. When enable=1, go to BLANK next cycle.
  - BLANK: blank=1, row_n=7'h7F. Counter increments. At counter==BLANK_CYCLES-1, go to DRIVE.
  - DRIVE: blank=0, row_n = ~active[col_sel]. Counter increments. At counter==CLK_DIV-1: counter=0, go to BLANK. col_sel advances (wraps NUM_COLS-1 -> 0).
- Slot length is exactly CLK_DIV cycles: BLANK_CYCLES blank + (CLK_DIV - BLANK_CYCLES) drive. Frame length = NUM_COLS*CLK_DIV cycles.
- col_sel changes only on the slot-boundary edge, so it is already stable at the start of BLANK.
- enable=0 in any state: IDLE on the next edge, col_sel=0, counter=0, no frame_done. Buffers and pending are kept. Re-enable restarts at column 0 BLANK.
- Load:
  - load=1 writes load_data into shadow, sets pending=1, and pulses load_ack next cycle.
  - Accepted in every state, including IDLE.
  - Back-to-back loads: last write wins, one ack per load.
- Swap: on the wrap edge (DRIVE, col_sel==NUM_COLS-1, counter==CLK_DIV-1):
  - frame_done pulses for that cycle.
  - If pending=1: active<=shadow, pending<=0.
- Load coinciding with the swap edge:
  - The swap uses the pre-edge shadow contents.
  - The new data lands in shadow and pending stays 1, so it is displayed after the next frame.
- In IDLE with pending=1, active<=shadow and pending<=0 immediately, so the first frame after enable shows the latest image.
- Widths:
  - Counter is clog2(CLK_DIV) bits.
  - col_sel compare is exact; values >= NUM_COLS are never produced.
  - No arithmetic overflow is possible.
- Reset asserted mid-frame: all outputs return to reset values immediately. A frame_done or load_ack in flight is dropped.
- All outputs are registered. row_n/blank never glitch on column change, because the blank phase covers the col_sel transition.

Decomposition:
- Shared package holds:
  - NUM_ROWS=7 and default NUM_COLS=5
  - state encoding IDLE/BLANK/DRIVE (2-bit)
  - ROWS_OFF=7'h7F
  - column-slice helper for the 35-bit image layout
- One natural sub-module: scan_slot_timer, the counter producing blank_end and slot_end ticks from CLK_DIV and BLANK_CYCLES, with synchronous clear on enable=0.
- FSM, buffers and load logic stay in matrix_scan_ctrl.

Test Plan (sim params CLK_DIV=8, BLANK_CYCLES=2, NUM_COLS=5):
1. Reset, then enable=1, no load -> col_sel cycles 0,1,2,3,4,0 every 8 cycles; row_n=7'h7F throughout; frame_done pulses every 40 cycles.
2. In IDLE, load with column 0=7'h55, column 4=7'h01, others 0; then enable -> load_ack 1 cycle after load; pending clears in IDLE; col 0 drive row_n=7'h2A, col 4 drive row_n=7'h7E; first 2 cycles of each slot blank=1, row_n=7'h7F.
3. While scanning frame A, load image B at col_sel=2 -> pending=1; frame A continues unchanged to col 4; B is visible from the next col 0; pending=0 after the frame_done edge.
4. Load asserted exactly on the frame_done cycle -> the swap takes the old shadow; pending stays 1; the new image appears one frame later.
5. Drop enable at col_sel=3 mid-drive -> next cycle IDLE, blank=1, col_sel=0, no frame_done; re-enable restarts at col 0 with 2 blank cycles.
6. Assert reset mid-DRIVE at col_sel=2 with pending=1 -> outputs immediately at reset values, pending=0; after release with enable=1, row_n stays 7'h7F (buffers cleared).

Source files
------------

// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the 5x7 dot-matrix scan controller: geometry, FSM
// encoding and the helper that picks one column out of a packed frame image.
package matrix_scan_ctrl_pkg;

    localparam int NUM_ROWS         = 7;
    localparam int NUM_COLS_DEFAULT = 5;
    localparam int MAX_COLS         = 8;
    localparam int MAX_IMG_W        = NUM_ROWS * MAX_COLS;

    localparam logic [NUM_ROWS-1:0] ROWS_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Image layout: bits [7c+6:7c] hold rows 6..0 of column c, 1 = LED on.
    function automatic logic [NUM_ROWS-1:0] column_slice(
        input logic [MAX_IMG_W-1:0] image,
        input logic [2:0]           col
    );
        return image[col*NUM_ROWS +: NUM_ROWS];
    endfunction

endpackage

// File: rtl/matrix_scan_ctrl_scan_slot_timer.sv
// Column-slot counter: counts through one slot and flags the last blank cycle
// and the last cycle of the slot. Held at zero whenever the scan is not running.
module scan_slot_timer #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_r;

    assign blank_end = (count_r == LAST_BLANK);
    assign slot_end  = (count_r == LAST_SLOT);

    // Slot counter: wraps at the slot boundary, cleared synchronously when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (!run) begin
            count_r <= '0;
        end else if (slot_end) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Dot-matrix scan controller: steps the column select, drives active-low rows
// with a blanking gap per slot, and double-buffers the frame image.
module matrix_scan_ctrl
    import matrix_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4,
    parameter int NUM_COLS     = NUM_COLS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         load,
    input  logic [NUM_ROWS*NUM_COLS-1:0] load_data,
    output logic                         load_ack,
    output logic [2:0]                   col_sel,
    output logic [NUM_ROWS-1:0]          row_n,
    output logic                         blank,
    output logic                         frame_done,
    output logic                         pending
);

    localparam int         IMG_W    = NUM_ROWS * NUM_COLS;
    localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);

    scan_state_t          state_r;
    logic [IMG_W-1:0]     active_r;
    logic [IMG_W-1:0]     shadow_r;
    logic [MAX_IMG_W-1:0] active_pad_s;
    logic                 blank_end_s;
    logic                 slot_end_s;
    logic                 timer_run_s;
    logic                 wrap_s;
    logic                 swap_s;

    assign timer_run_s = enable && (state_r != ST_IDLE);

    scan_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (timer_run_s),
        .blank_end (blank_end_s),
        .slot_end  (slot_end_s)
    );

    // The last edge of the last column ends the frame; idle also drains the shadow.
    assign wrap_s = enable && (state_r == ST_DRIVE) && slot_end_s && (col_sel == LAST_COL);
    assign swap_s = pending && (wrap_s || (state_r == ST_IDLE));

    // Widen the live image to the fixed layout the slice helper works on.
    always_comb begin
        active_pad_s = '0;
        active_pad_s[IMG_W-1:0] = active_r;
    end

    // Scan FSM with registered column, row and blank outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            col_sel    <= 3'd0;
            row_n      <= ROWS_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            state_r    <= ST_IDLE;
            col_sel    <= 3'd0;
            row_n      <= ROWS_OFF;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_BLANK;
                    col_sel    <= 3'd0;
                    row_n      <= ROWS_OFF;
                    blank      <= 1'b1;
                    frame_done <= 1'b0;
                end
                ST_BLANK: begin
                    frame_done <= 1'b0;
                    if (blank_end_s) begin
                        state_r <= ST_DRIVE;
                        blank   <= 1'b0;
                        row_n   <= ~column_slice(active_pad_s, col_sel);
                    end else begin
                        state_r <= ST_BLANK;
                        blank   <= 1'b1;
                        row_n   <= ROWS_OFF;
                    end
                end
                ST_DRIVE: begin
                    if (slot_end_s) begin
                        // col_sel moves only here, under the blank that follows.
                        state_r    <= ST_BLANK;
                        blank      <= 1'b1;
                        row_n      <= ROWS_OFF;
                        frame_done <= (col_sel == LAST_COL);
                        col_sel    <= (col_sel == LAST_COL) ? 3'd0 : col_sel + 3'd1;
                    end else begin
                        state_r    <= ST_DRIVE;
                        frame_done <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    col_sel    <= 3'd0;
                    row_n      <= ROWS_OFF;
                    blank      <= 1'b1;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

    // Double buffer: loads land in the shadow, the swap reads the pre-edge shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_r <= '0;
            shadow_r <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            load_ack <= load;
            if (load) begin
                shadow_r <= load_data;
            end
            if (swap_s) begin
                active_r <= shadow_r;
            end
            pending <= load || (pending && !swap_s);
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: a frame-position model pushes
// the expected outputs for every clock, and each scenario pops and compares.
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int NCOLS   = 5;
    localparam int FRAME   = CLK_DIV * NCOLS;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [34:0] load_data;
    logic        load_ack;
    logic [2:0]  col_sel;
    logic [6:0]  row_n;
    logic        blank;
    logic        frame_done;
    logic        pending;

    typedef struct packed {
        logic [2:0] col;
        logic [6:0] row;
        logic       blank;
        logic       fd;
        logic       pend;
        logic       ack;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [13:0] obs;
    int          errors = 0;
    int          checks = 0;

    bit          m_run;
    int          m_pos;
    logic [34:0] m_active;
    logic [34:0] m_shadow;
    logic        m_pending;

    matrix_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK),
        .NUM_COLS     (NCOLS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .load_data  (load_data),
        .load_ack   (load_ack),
        .col_sel    (col_sel),
        .row_n      (row_n),
        .blank      (blank),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] mk_img(input logic [6:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    task automatic model_reset();
        m_run     = 1'b0;
        m_pos     = 0;
        m_active  = 35'd0;
        m_shadow  = 35'd0;
        m_pending = 1'b0;
        sb.delete();
    endtask

    // Predicts outputs after the coming edge from the frame position.
    task automatic model_step(input logic en, input logic ld, input logic [34:0] d);
        exp_t x;
        bit   wrap;
        bit   swap;
        int   col;
        int   off;
        wrap = m_run && en && (m_pos == FRAME - 1);
        swap = m_pending && (wrap || !m_run);
        x.ack = ld;
        x.fd  = wrap;
        if (swap) m_active = m_shadow;
        if (ld) m_shadow = d;
        m_pending = ld ? 1'b1 : (swap ? 1'b0 : m_pending);
        m_pos = (en && m_run) ? ((m_pos + 1) % FRAME) : 0;
        m_run = en;
        x.pend = m_pending;
        col = m_pos / CLK_DIV;
        off = m_pos % CLK_DIV;
        if (!m_run) begin
            x.col   = 3'd0;
            x.row   = 7'h7F;
            x.blank = 1'b1;
        end else begin
            x.col   = 3'(col);
            x.blank = (off < BLANK);
            x.row   = x.blank ? 7'h7F : ~m_active[7*col +: 7];
        end
        sb.push_back(x);
    endtask

    task automatic tick(input logic en, input logic ld, input logic [34:0] d);
        enable    = en;
        load      = ld;
        load_data = d;
        model_step(en, ld, d);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_data = 35'd0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({col_sel, row_n, blank} !== {3'd0, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_scan: got col=%0d row=%h blank=%b want col=0 row=7f blank=1", col_sel, row_n, blank);
        end
        checks++;
        if ({load_ack, frame_done, pending} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got ack=%b fd=%b pend=%b want 0 0 0", load_ack, frame_done, pending);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        int fd_count = 0;
        for (int i = 0; i < 2*FRAME + 5; i++) begin
            tick(1'b1, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL scan cyc %0d: got %h want %h", i, obs, e); end
            if (frame_done === 1'b1) fd_count++;
        end
        checks++;
        if (fd_count != 2) begin errors++; $display("FAIL scan_fd_count: got %0d want 2", fd_count); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL scan_stop cyc %0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_idle_load();
        tick(1'b0, 1'b1, mk_img(7'h55, 7'h00, 7'h00, 7'h00, 7'h01));
        for (int i = 0; i < FRAME + 3; i++) begin
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL idle_load cyc %0d: got %h want %h", i, obs, e); end
            if (i == 2) begin
                checks++;
                if (row_n !== 7'h7F) begin errors++; $display("FAIL idle_load_blank0: got %h want 7f", row_n); end
            end
            if (i == 4) begin
                checks++;
                if (row_n !== 7'h2A) begin errors++; $display("FAIL idle_load_col0: got %h want 2a", row_n); end
            end
            tick((i >= 1), 1'b0, 35'd0);
        end
        e = sb.pop_front();
    endtask

    task automatic test_load_midframe();
        for (int i = 0; i < FRAME && !(m_run && m_pos == 2*CLK_DIV + 1); i++) begin
            tick(1'b1, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL midframe_pre cyc %0d: got %h want %h", i, obs, e); end
        end
        tick(1'b1, 1'b1, mk_img(7'h01, 7'h02, 7'h04, 7'h08, 7'h10));
        for (int i = 0; i < 2*FRAME; i++) begin
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL midframe cyc %0d: got %h want %h", i, obs, e); end
            tick(1'b1, 1'b0, 35'd0);
        end
        e = sb.pop_front();
    endtask

    task automatic test_load_on_swap();
        tick(1'b1, 1'b1, mk_img(7'h7F, 7'h00, 7'h3C, 7'h00, 7'h40));
        for (int i = 0; i < 2*FRAME && !(m_run && m_pos == FRAME - 1); i++) begin
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL swap_pre cyc %0d: got %h want %h", i, obs, e); end
            tick(1'b1, 1'b0, 35'd0);
        end
        e = sb.pop_front();
        tick(1'b1, 1'b1, mk_img(7'h11, 7'h22, 7'h33, 7'h44, 7'h55));
        for (int i = 0; i < 2*FRAME; i++) begin
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL swap_edge cyc %0d: got %h want %h", i, obs, e); end
            if (i == 0) begin
                checks++;
                if ({frame_done, pending} !== 2'b11) begin
                    errors++; $display("FAIL swap_edge_flags: got fd=%b pend=%b want 1 1", frame_done, pending);
                end
            end
            tick(1'b1, 1'b0, 35'd0);
        end
        e = sb.pop_front();
    endtask

    task automatic test_disable_mid();
        for (int i = 0; i < FRAME && !(m_run && m_pos == 3*CLK_DIV + 3); i++) begin
            tick(1'b1, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL disable_pre cyc %0d: got %h want %h", i, obs, e); end
        end
        for (int i = 0; i < CLK_DIV + 8; i++) begin
            tick((i >= 3), 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL disable cyc %0d: got %h want %h", i, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b1, mk_img(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F));
        e = sb.pop_front();
        for (int i = 0; i < 2*FRAME && !(m_run && m_pos == 2*CLK_DIV + 4); i++) begin
            tick(1'b1, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL rstmid_pre cyc %0d: got %h want %h", i, obs, e); end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({col_sel, row_n, blank, frame_done, pending, load_ack} !== {3'd0, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: got col=%0d row=%h bl=%b fd=%b pend=%b ack=%b want 0 7f 1 0 0 0",
                     col_sel, row_n, blank, frame_done, pending, load_ack);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            tick(1'b1, 1'b0, 35'd0);
            e = sb.pop_front(); obs = {col_sel, row_n, blank, frame_done, pending, load_ack}; checks++;
            if (obs !== e) begin errors++; $display("FAIL rstmid_after cyc %0d: got %h want %h", i, obs, e); end
            checks++;
            if (row_n !== 7'h7F) begin errors++; $display("FAIL rstmid_dark cyc %0d: got %h want 7f", i, row_n); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_idle_load();
        test_load_midframe();
        test_load_on_swap();
        test_disable_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
